sme_feeder: RTL

SME_FEEDER -- requirements
Module: sme_feeder

---
 rtl/sme_feeder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sme_feeder.sv
// sme_feeder: buffers host string/pattern records and streams them to the
// matcher one character per cycle, then waits for the matcher result.
module sme_feeder #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned WDOG    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_type,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  output logic       busy,
  output logic       err,
  output logic [7:0] pat_done
);

  localparam int unsigned LW = 6;
  localparam int unsigned WW = 7;
  localparam int unsigned AW = $clog2(STR_MAX);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d, lim;
  logic [WW-1:0] wdog_q, wdog_d;
  logic        rtype_q, rtype_d, rtype_cur;
  logic        str_loaded_q, str_loaded_d;
  logic        err_q, err_d;
  logic [7:0]  pat_done_q, pat_done_d;
  logic [7:0]  chardata_q, chardata_d;
  logic        isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic        in_ready_q, in_ready_d, busy_q, busy_d;
  logic        accept, drop_cur, emit_done, wd_expire;
  logic        wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]  buf_q [STR_MAX];

  assign accept    = in_valid && in_ready_q;
  assign rtype_cur = (state_q == S_IDLE) ? in_type : rtype_q;
  assign lim       = rtype_cur ? LW'(PAT_MAX) : LW'(STR_MAX);
  assign drop_cur  = rtype_cur && !str_loaded_q;
  assign emit_done = (idx_q == len_q);
  assign wd_expire = (wdog_q == WW'(WDOG - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (in_last) state_d = drop_cur ? S_IDLE : S_EMIT;
        else         state_d = S_LOAD;
      end
      S_LOAD: if (accept && in_last) state_d = drop_cur ? S_IDLE : S_EMIT;
      S_EMIT: if (emit_done) state_d = rtype_q ? S_WAIT : S_IDLE;
      S_WAIT: if (valid || wd_expire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    len_d        = len_q;
    idx_d        = idx_q;
    wdog_d       = wdog_q;
    rtype_d      = rtype_q;
    str_loaded_d = str_loaded_q;
    err_d        = err_q;
    pat_done_d   = pat_done_q;
    chardata_d   = chardata_q;
    isstring_d   = 1'b0;
    ispattern_d  = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = len_q[AW-1:0];
    unique case (state_q)
      S_IDLE: if (accept) begin
        rtype_d = in_type;
        wr_en   = 1'b1;
        wr_addr = '0;
        len_d   = LW'(1);
        idx_d   = '0;
      end
      S_LOAD: if (accept) begin
        if (len_q < lim) begin
          wr_en = 1'b1;
          len_d = len_q + LW'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      S_EMIT: begin
        if (!emit_done) begin
          chardata_d  = buf_q[idx_q[AW-1:0]];
          isstring_d  = !rtype_q;
          ispattern_d = rtype_q;
          idx_d       = idx_q + LW'(1);
        end else begin
          idx_d  = '0;
          wdog_d = '0;
          if (!rtype_q) str_loaded_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (valid) begin
          pat_done_d = pat_done_q + 8'd1;
          wdog_d     = '0;
        end else if (wd_expire) begin
          err_d  = 1'b1;
          wdog_d = '0;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      default: ;
    endcase
    // Pattern with no string to match against: swallow it and flag
    if (accept && in_last && drop_cur) err_d = 1'b1;
    // First character goes out the cycle after the closing byte is taken
    if (state_q != S_EMIT && state_d == S_EMIT) begin
      chardata_d  = (state_q == S_IDLE) ? in_data : buf_q[0];
      isstring_d  = !rtype_cur;
      ispattern_d = rtype_cur;
      idx_d       = LW'(1);
    end
  end

  assign in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  assign busy_d     = (state_d != S_IDLE);

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      idx_q        <= '0;
      wdog_q       <= '0;
      rtype_q      <= 1'b0;
      str_loaded_q <= 1'b0;
      err_q        <= 1'b0;
      pat_done_q   <= '0;
      chardata_q   <= '0;
      isstring_q   <= 1'b0;
      ispattern_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      len_q        <= len_d;
      idx_q        <= idx_d;
      wdog_q       <= wdog_d;
      rtype_q      <= rtype_d;
      str_loaded_q <= str_loaded_d;
      err_q        <= err_d;
      pat_done_q   <= pat_done_d;
      chardata_q   <= chardata_d;
      isstring_q   <= isstring_d;
      ispattern_q  <= ispattern_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Record buffer, contents meaningless until written
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign pat_done  = pat_done_q;
  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;

endmodule
